muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multi-cycle HI/LO arithmetic unit for the 5-stage pipelined CPU, executing MULTU, MADDU and DIVU over a parametrised operand width. Sits beside the ALU in EX; the ALU control decode drives `op`/`start` and `rd_sel`. Exposes `stall` so the hazard logic freezes the pipeline while an operation is in flight.

## Interface
- `WIDTH`, 32, operand and HI/LO width; legal values are ≥ 4.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request to launch `op` this cycle
- `op`  in  2  operation: 0 none, 1 MULTU, 2 MADDU, 3 DIVU
- `a`  in  WIDTH  operand rs (multiplicand/dividend)
- `b`  in  WIDTH  operand rt (multiplier/divisor)
- `rd_sel`  in  2  01 read HI (mfhi), 10 read LO (mflo), else none
- `rd_data`  out  WIDTH  selected HI/LO; 0 when `rd_sel` is none
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle pulse: result committed
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers
- `stall`  out  1  pipeline must hold

## Operation
- States: IDLE, RUN. Iteration counter `cnt`, width $clog2(WIDTH)+1.
- IDLE and `start`=1 with legal `op` ≠ 0: latch `a`, `b` and `op`; clear `cnt` and the working registers; go to RUN.
- RUN: one iteration per edge. Increment `cnt`. On the edge completing iteration WIDTH-1, commit HI/LO, set `done`=1 for one cycle and return to IDLE.
- MULTU: radix-2 shift-add. {HI,LO} = a*b. Full 2·WIDTH-bit product.
- MADDU: same product. At commit, {HI,LO} = {HI,LO} + a*b modulo 2^(2·WIDTH); the carry-out is dropped.
- DIVU: restoring unsigned division. LO = quotient, HI = remainder.
- DIVU with divisor 0: LO = all ones, HI = a. Latency is unchanged.
- `start` while `busy` is ignored. Latched operands are not disturbed.
- `busy` = (state == RUN).
- `stall` = `busy` & (`rd_sel` ∈ {01,10} | `start`).
- `rd_data` is a combinational mux of the HI/LO registers. No bypass of in-flight results.
- `rst` at any time, including mid-RUN: state IDLE, HI = LO = 0, `done` = 0, working registers cleared. No commit occurs.

## Timing
- Reset values: `busy` 0, `done` 0, `hi` 0, `lo` 0, `stall` 0, `rd_data` 0.
- `start` sampled at edge E0. `busy` is high from after E0 through edge E0+WIDTH.
- HI/LO update at edge E0+WIDTH. `done` is high for the cycle following that edge.
- A new `start` is accepted in the same cycle `done` is high, because the state is IDLE.
- `rd_sel` in the `done` cycle returns the new HI/LO values.
- Back-to-back issue: one operation every WIDTH+1 cycles.

## Configuration
- `MULDIV_DIVU_EN` defined: the DIVU datapath and op 3 are supported as described.
- `MULDIV_DIVU_EN` undefined: the divider logic is not compiled. `start` with op 3 is ignored: no `busy`, no `done`, and HI/LO unchanged.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings `OP_NONE`, `OP_MULTU`, `OP_MADDU`, `OP_DIVU`;
  - `rd_sel` encodings `SEL_HI`, `SEL_LO`;
  - state encodings `S_IDLE`, `S_RUN`.
- One sub-module, `muldiv_divstep`: a combinational restoring-division step producing next remainder and quotient bit. It is compiled only under `MULDIV_DIVU_EN`.
- The shift-add step, FSM and HI/LO registers live in `muldiv_unit`.

## Test plan
All scenarios use WIDTH=32.

- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `done` high exactly in the cycle after the 32nd edge after `start`. `busy` is high for 32 cycles.
- After the previous scenario, MADDU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFC, LO=0x00000002 (wrap, carry dropped).
- DIVU 100/7 → LO=14, HI=2. Then DIVU 5/0 → LO=0xFFFFFFFF, HI=5. Both take 32 iterations.
- While `busy`:
  - `rd_sel`=01 → `stall`=1.
  - `start` with op=MULTU a=3 b=3 → `stall`=1, ignored; the running result is unaffected.
  - In the `done` cycle, `rd_sel`=10 → `rd_data` = new LO and `stall`=0.
- `rst` pulsed at iteration 10 of a MULTU → `busy` 0 immediately, HI=LO=0, no `done` pulse. A fresh MULTU 6*7 afterwards gives LO=42, HI=0.
- Build without `MULDIV_DIVU_EN`: `start` with op=3 → `busy` stays 0, no `done`, HI/LO hold prior values.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the HI/LO multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_MULTU = 2'd1,
      OP_MADDU = 2'd2,
      OP_DIVU  = 2'd3
   } op_e;

   localparam logic [1:0] SEL_HI = 2'b01;
   localparam logic [1:0] SEL_LO = 2'b10;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage request/response bundle between the pipeline and muldiv_unit.
interface muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       rd_sel;
   logic [WIDTH-1:0] rd_data;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             stall;

   // Pipeline side: issues operations and reads HI/LO.
   modport master (
      output start, op, a, b, rd_sel,
      input  rd_data, busy, done, hi, lo, stall
   );

   // Unit side.
   modport slave (
      input  start, op, a, b, rd_sel,
      output rd_data, busy, done, hi, lo, stall
   );
endinterface

// File: rtl/muldiv_divstep.sv
// muldiv_divstep: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and subtracts the divisor when it fits.
module muldiv_divstep #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] trial;

   // Trial subtraction; a zero divisor always "fits", giving all-ones quotient and rem = dividend.
   always_comb begin
      trial   = {rem_in, dividend_bit};
      q_bit   = (trial >= {1'b0, divisor});
      rem_out = q_bit ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULTU/MADDU/DIVU unit with architectural HI/LO registers.
// One iteration per clock for WIDTH clocks; commit and one-cycle done at the last edge.
// Macro MULDIV_DIVU_EN: when defined, compiles the divider and accepts op DIVU;
// otherwise a DIVU request is ignored.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic     clk,
   input logic     rst,
   muldiv_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   op_e                op_q;
   logic [WIDTH-1:0]   opnd_q;   // multiplicand, or divisor for DIVU
   logic [2*WIDTH-1:0] acc_q;    // {partial product, multiplier} or {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] hilo_d;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               done_q;
   logic               legal_op, launch, last;
   logic [WIDTH:0]     mul_sum;

`ifdef MULDIV_DIVU_EN
   logic [WIDTH-1:0] div_rem;
   logic             div_qbit;

   muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
      .rem_in       (acc_q[2*WIDTH-1:WIDTH]),
      .dividend_bit (acc_q[WIDTH-1]),
      .divisor      (opnd_q),
      .rem_out      (div_rem),
      .q_bit        (div_qbit)
   );
`endif

   // Decode which requested ops this build can execute.
   always_comb begin
      legal_op = 1'b0;
      case (op_e'(bus.op))
         OP_MULTU, OP_MADDU: legal_op = 1'b1;
`ifdef MULDIV_DIVU_EN
         OP_DIVU:            legal_op = 1'b1;
`endif
         default:            legal_op = 1'b0;
      endcase
   end

   assign launch = (state_q == S_IDLE) && bus.start && legal_op;
   assign last   = (state_q == S_RUN) && (cnt_q == LAST_ITER);

   // FSM next state: requests while busy are simply not looked at.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (launch) state_d = S_RUN;
         S_RUN:   if (last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // One datapath iteration: shift-add multiply step, or restoring divide step for DIVU.
   always_comb begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MULDIV_DIVU_EN
      if (op_q == OP_DIVU) acc_d = {div_rem, acc_q[WIDTH-2:0], div_qbit};
`endif
   end

   // Commit value: DIVU's {rem, quot} lands in {HI, LO} like a product; MADDU accumulates.
   always_comb begin
      hilo_d = acc_d;
      if (op_q == OP_MADDU) hilo_d = {hi_q, lo_q} + acc_d;
   end

   // Operand latch, iteration counter, working register, HI/LO commit and done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         op_q   <= OP_NONE;
         opnd_q <= '0;
         acc_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= last;
         if (launch) begin
            cnt_q  <= '0;
            op_q   <= op_e'(bus.op);
            opnd_q <= bus.a;
            acc_q  <= {{WIDTH{1'b0}}, bus.b};
`ifdef MULDIV_DIVU_EN
            if (bus.op == OP_DIVU) begin
               opnd_q <= bus.b;
               acc_q  <= {{WIDTH{1'b0}}, bus.a};
            end
`endif
         end else if (state_q == S_RUN) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_d;
         end
         if (last) begin
            hi_q <= hilo_d[2*WIDTH-1:WIDTH];
            lo_q <= hilo_d[WIDTH-1:0];
         end
      end
   end

   // mfhi/mflo read port; reads the committed registers only.
   always_comb begin
      bus.rd_data = '0;
      case (bus.rd_sel)
         SEL_HI:  bus.rd_data = hi_q;
         SEL_LO:  bus.rd_data = lo_q;
         default: bus.rd_data = '0;
      endcase
   end

   assign bus.busy  = (state_q == S_RUN);
   assign bus.done  = done_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.stall = bus.busy && ((bus.rd_sel == SEL_HI) || (bus.rd_sel == SEL_LO) || bus.start);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors; expected results go to a scoreboard checked on done,
// and per-cycle expectations go to a probe queue checked by the same monitor.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int unsigned WIDTH = 32;

   typedef enum int {P_BUSY, P_STALL, P_RDDATA, P_HI, P_LO} probe_e;

   typedef struct {
      int          at;
      probe_e      kind;
      logic [31:0] exp;
      string       name;
   } probe_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
      string       name;
   } result_t;

   logic    clk = 1'b0;
   logic    rst = 1'b1;
   int      cyc = 0;
   int      checks = 0;
   int      errors = 0;
   bit      fin = 1'b0;
   int      t0;
   probe_t  probes[$];
   result_t sb[$];

   muldiv_if #(.WIDTH(WIDTH)) bus ();

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic void probe(input int off, input probe_e kind, input logic [31:0] exp,
                                 input string name);
      probe_t p;
      p.at   = cyc + off;
      p.kind = kind;
      p.exp  = exp;
      p.name = name;
      probes.push_back(p);
   endfunction

   // Drive start for one cycle; when tracked, expect a commit WIDTH+1 cycles later.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit track,
                        input string name);
      result_t r;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      if (track) begin
         r.hi   = ehi;
         r.lo   = elo;
         r.due  = cyc + WIDTH + 1;
         r.name = name;
         sb.push_back(r);
         probe(1, P_BUSY, 32'd1, {name, "_busy_first"});
         probe(WIDTH, P_BUSY, 32'd1, {name, "_busy_last"});
         probe(WIDTH + 1, P_BUSY, 32'd0, {name, "_busy_clear"});
      end
      step(1);
      bus.start = 1'b0;
      bus.op    = 2'd0;
   endtask

   function automatic logic [31:0] sample(input probe_e kind);
      case (kind)
         P_BUSY:   return {31'd0, bus.busy};
         P_STALL:  return {31'd0, bus.stall};
         P_RDDATA: return bus.rd_data;
         P_HI:     return bus.hi;
         default:  return bus.lo;
      endcase
   endfunction

   // Monitor: pops the scoreboard on done, evaluates probes due this cycle, prints the summary.
   always @(negedge clk) begin
      result_t     r;
      logic [31:0] act;
      if (bus.done) begin
         if (sb.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_done: done seen at cycle %0d with nothing pending", cyc);
         end else begin
            r = sb.pop_front();
            checks = checks + 3;
            if (bus.hi !== r.hi) begin
               errors = errors + 1;
               $display("FAIL %s_hi: got %h expected %h", r.name, bus.hi, r.hi);
            end
            if (bus.lo !== r.lo) begin
               errors = errors + 1;
               $display("FAIL %s_lo: got %h expected %h", r.name, bus.lo, r.lo);
            end
            if (cyc != r.due) begin
               errors = errors + 1;
               $display("FAIL %s_done_cycle: got %0d expected %0d", r.name, cyc, r.due);
            end
         end
      end
      for (int i = probes.size() - 1; i >= 0; i--) begin
         if (probes[i].at == cyc) begin
            act = sample(probes[i].kind);
            checks = checks + 1;
            if (act !== probes[i].exp) begin
               errors = errors + 1;
               $display("FAIL %s: got %h expected %h", probes[i].name, act, probes[i].exp);
            end
            probes.delete(i);
         end
      end
      if (fin) begin
         foreach (sb[i]) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_missing_done: got no done expected done at cycle %0d",
                     sb[i].name, sb[i].due);
         end
         foreach (probes[i]) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_not_sampled: got none expected sample at cycle %0d",
                     probes[i].name, probes[i].at);
         end
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   initial begin
      bus.start  = 1'b0;
      bus.op     = 2'd0;
      bus.a      = '0;
      bus.b      = '0;
      bus.rd_sel = SEL_HI;

      // Reset values.
      step(2);
      probe(0, P_BUSY, 32'd0, "rst_busy");
      probe(0, P_STALL, 32'd0, "rst_stall");
      probe(0, P_RDDATA, 32'd0, "rst_rd_data");
      probe(0, P_HI, 32'd0, "rst_hi");
      probe(0, P_LO, 32'd0, "rst_lo");
      step(1);
      rst        = 1'b0;
      bus.rd_sel = 2'b00;
      step(2);

      // MULTU max*max with stall and ignored-start checks while busy.
      t0 = cyc;
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1,
            "multu_max");
      step(4);
      bus.rd_sel = SEL_HI;
      probe(0, P_STALL, 32'd1, "stall_mfhi_busy");
      probe(0, P_RDDATA, 32'd0, "rd_hi_no_bypass");
      step(1);
      bus.rd_sel = 2'b00;
      bus.start  = 1'b1;
      bus.op     = OP_MULTU;
      bus.a      = 32'd3;
      bus.b      = 32'd3;
      probe(0, P_STALL, 32'd1, "stall_start_busy");
      step(1);
      bus.start = 1'b0;
      bus.op    = 2'd0;
      probe(0, P_STALL, 32'd0, "no_stall_busy_quiet");
      while (cyc < t0 + WIDTH + 1) step(1);

      // Done cycle: mflo sees the new LO, no stall, and a back-to-back MADDU is accepted.
      bus.rd_sel = SEL_LO;
      probe(0, P_RDDATA, 32'h0000_0001, "mflo_done_cycle");
      probe(0, P_STALL, 32'd0, "stall_done_cycle");
      t0 = cyc;
      issue(OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0002, 1'b1,
            "maddu_wrap");
      bus.rd_sel = 2'b00;
      while (cyc < t0 + WIDTH + 1) step(1);
      bus.rd_sel = 2'b11;
      probe(0, P_RDDATA, 32'd0, "rd_sel_11_zero");
      step(1);
      bus.rd_sel = 2'b00;

`ifdef MULDIV_DIVU_EN
      t0 = cyc;
      issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, "divu_100_7");
      while (cyc < t0 + WIDTH + 1) step(1);
      t0 = cyc;
      issue(OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, "divu_5_0");
      while (cyc < t0 + WIDTH + 1) step(1);
`else
      issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, "divu_off");
      probe(0, P_BUSY, 32'd0, "divu_off_busy");
      step(WIDTH + 2);
      probe(0, P_HI, 32'hFFFF_FFFC, "divu_off_hi_hold");
      probe(0, P_LO, 32'h0000_0002, "divu_off_lo_hold");
      step(1);
`endif

      // Reset during iteration 10 of a MULTU: no commit, no done.
      issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 1'b0, "multu_abort");
      step(9);
      rst = 1'b1;
      probe(0, P_BUSY, 32'd0, "abort_busy");
      probe(0, P_HI, 32'd0, "abort_hi");
      probe(0, P_LO, 32'd0, "abort_lo");
      step(1);
      rst = 1'b0;
      step(WIDTH + 4);

      t0 = cyc;
      issue(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, "multu_6_7");
      while (cyc < t0 + WIDTH + 1) step(1);
      step(3);

      fin = 1'b1;
      step(5);
      $display("FAIL monitor_stuck: got no summary expected summary");
      $fatal(1);
   end

endmodule
